grid_led_scan: RTL

- Consumer end of the evolved-grid path: accepts a completed 64-bit generation over a valid/ready handshake and drives an 8x8 LED matrix by multiplexed row scanning.
- Double-buffered. A pending buffer takes the new generation and a display buffer is scanned. A swap happens only at a frame boundary, so a frame never tears.
- Sits after the evolve register and sits on the board-facing side of the design.

---
 rtl/grid_led_scan_if.sv | 18 +
 rtl/grid_led_scan.sv | 139 +++++++++++++
 2 files changed

// File: rtl/grid_led_scan_if.sv
// Generation handoff into the LED scanner: 64-bit grid with a valid/ready handshake.
interface grid_led_scan_if;
  logic [63:0] grid_in;
  logic        grid_valid;
  logic        grid_ready;

  modport master (
    output grid_in,
    output grid_valid,
    input  grid_ready
  );

  modport slave (
    input  grid_in,
    input  grid_valid,
    output grid_ready
  );
endinterface

// File: rtl/grid_led_scan.sv
// Double-buffered 8x8 LED row scanner. Accepts a generation, swaps it in only at a frame boundary.
// Accept-to-row-0 takes two cycles. ready drops while a generation is pending. Define ROW_BLANK_EN to add a blank cycle after each row.
module grid_led_scan #(
  parameter int DWELL          = 1000,
  parameter bit COL_ACTIVE_LOW = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  grid_led_scan_if.slave  grid_if,
  output logic [7:0]      row_sel,
  output logic [7:0]      col_data,
  output logic            frame_done
);

  localparam int             DW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0]  D_LAST   = DW'(DWELL - 1);
  localparam logic [7:0]     COL_IDLE = COL_ACTIVE_LOW ? 8'hFF : 8'h00;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    r_q, r_d;
  logic [DW-1:0] d_q, d_d;
  logic [63:0]   pend_buf_q, pend_buf_d;
  logic          pend_vld_q, pend_vld_d;
  logic [63:0]   disp_buf_q, disp_buf_d;
  logic          frame_end;
  logic          advance;
  logic          row_lit;
  logic [7:0]    row_byte;

`ifdef ROW_BLANK_EN
  logic blank_q, blank_d;
`else
  logic blank_q;
  assign blank_q = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      r_q        <= 3'd0;
      d_q        <= '0;
      pend_buf_q <= 64'd0;
      pend_vld_q <= 1'b0;
      disp_buf_q <= 64'd0;
`ifdef ROW_BLANK_EN
      blank_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      d_q        <= d_d;
      pend_buf_q <= pend_buf_d;
      pend_vld_q <= pend_vld_d;
      disp_buf_q <= disp_buf_d;
`ifdef ROW_BLANK_EN
      blank_q    <= blank_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    d_d        = d_q;
    pend_buf_d = pend_buf_q;
    pend_vld_d = pend_vld_q;
    disp_buf_d = disp_buf_q;
    frame_end  = 1'b0;
    advance    = 1'b0;
`ifdef ROW_BLANK_EN
    blank_d    = blank_q;
`endif

    // Accept needs an empty pending slot, so it never collides with a swap below.
    if (grid_if.grid_valid && !pend_vld_q) begin
      pend_buf_d = grid_if.grid_in;
      pend_vld_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pend_vld_q) begin
          disp_buf_d = pend_buf_q;
          pend_vld_d = 1'b0;
          r_d        = 3'd0;
          d_d        = '0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
`ifdef ROW_BLANK_EN
        if (blank_q) begin
          blank_d = 1'b0;
          advance = 1'b1;
        end else if (d_q == D_LAST) begin
          blank_d = 1'b1;
          d_d     = '0;
        end else begin
          d_d = d_q + 1'b1;
        end
`else
        if (d_q == D_LAST) begin
          advance = 1'b1;
        end else begin
          d_d = d_q + 1'b1;
        end
`endif
        if (advance) begin
          d_d = '0;
          r_d = r_q + 3'd1;
          // Swapping only as row 7 finishes keeps every frame whole.
          if (r_q == 3'd7) begin
            frame_end = 1'b1;
            if (pend_vld_q) begin
              disp_buf_d = pend_buf_q;
              pend_vld_d = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grid_if.grid_ready = !pend_vld_q;

  // Row r lives in bits [63-8r -: 8]; {~r,3'b111} is exactly 63-8r.
  assign row_byte   = disp_buf_q[{~r_q, 3'b111} -: 8];
  assign row_lit    = (state_q == SCAN) && !blank_q;
  assign row_sel    = row_lit ? (8'd1 << r_q) : 8'h00;
  assign col_data   = (row_lit ? row_byte : 8'h00) ^ COL_IDLE;
  assign frame_done = frame_end;

endmodule
